control_actualizacion_vga: RTL and testbench

- Scheduler between the RTC read path and the VGA text/figure decoder.
- Accepts a 4-phase req/ack handshake carrying a full snapshot of the displayed values: time, date, programmed timer and running timer (12 bytes).
- Defers the register update to vertical blanking, so a frame never shows a half-updated field.
- Derives the cursor/alarm blink toggle from a frame count, in lockstep with the display.

---
 rtl/control_actualizacion_vga_if.sv | 13 +
 rtl/control_actualizacion_vga.sv | 111 +++++++++++
 tb/tb_control_actualizacion_vga.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/control_actualizacion_vga_if.sv
// Snapshot handshake between the RTC read path (master) and the VGA update
// scheduler (slave).
//   dato_req : master -> slave, held high until dato_ack is seen high
//   datos_in : master -> slave, 8*NUM_BYTES snapshot, stable while dato_req=1
//   dato_ack : slave -> master, high once the snapshot has been copied
interface control_actualizacion_vga_if #(parameter int NUM_BYTES = 12);
  logic                   dato_req;
  logic [8*NUM_BYTES-1:0] datos_in;
  logic                   dato_ack;

  modport master (output dato_req, output datos_in, input dato_ack);
  modport slave  (input dato_req, input datos_in, output dato_ack);
endinterface

// File: rtl/control_actualizacion_vga.sv
// Update scheduler between the RTC read path and the VGA text/figure decoder.
// A snapshot offered on the req/ack handshake is copied into datos_vga one
// byte per cycle, and only while vertical blanking is active at the start of
// the copy, so a visible frame never shows a half-updated field. A blink
// toggle is derived from the count of vblank starts.
// Ports:
//   reloj_nexys  : clock, rising edge
//   reset_total  : synchronous active-high reset
//   pixel_rate   : one-cycle pixel enable
//   pixel_y      : current line from the sync generator
//   hs           : snapshot handshake (dato_req, datos_in, dato_ack)
//   datos_vga    : registered values fed to the VGA decoder
//   actualizando : high while the copy is in progress
//   parpadeo     : blink toggle
//   en_vblank    : registered vblank flag
module control_actualizacion_vga #(
  parameter int NUM_BYTES       = 12,
  parameter int Y_VISIBLE       = 480,
  parameter int Y_TOTAL         = 525,
  parameter int PARPADEO_FRAMES = 30
) (
  input  logic                         reloj_nexys,
  input  logic                         reset_total,
  input  logic                         pixel_rate,
  input  logic [9:0]                   pixel_y,
  control_actualizacion_vga_if.slave   hs,
  output logic [8*NUM_BYTES-1:0]       datos_vga,
  output logic                         actualizando,
  output logic                         parpadeo,
  output logic                         en_vblank
);
  localparam int IDX_W   = $clog2(NUM_BYTES);
  localparam int FRAME_W = $clog2(PARPADEO_FRAMES);

  typedef enum logic [1:0] {ESPERA, PENDIENTE, COPIA, ACK} estado_t;

  estado_t                state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FRAME_W-1:0]     frame_q;
  logic [8*NUM_BYTES-1:0] datos_q;
  logic                   en_vblank_q, en_prev_q, parpadeo_q, ack_q, act_q;
  logic                   vis_blank, vblank_start;

  assign vis_blank    = (pixel_y >= 10'(Y_VISIBLE)) && (pixel_y < 10'(Y_TOTAL));
  // en_prev_q follows every cycle, so the rise is a single-cycle pulse even
  // though en_vblank_q only moves on pixel_rate cycles.
  assign vblank_start = en_vblank_q && !en_prev_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ESPERA:    if (hs.dato_req) state_d = en_vblank_q ? COPIA : PENDIENTE;
      // req withdrawal here is a protocol violation; the copy still happens.
      PENDIENTE: if (en_vblank_q) state_d = COPIA;
      COPIA: begin
        if (idx_q == IDX_W'(NUM_BYTES-1)) begin
          idx_d   = '0;
          state_d = ACK;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ACK:       if (!hs.dato_req) state_d = ESPERA;
      default:   state_d = ESPERA;
    endcase
  end

  always_ff @(posedge reloj_nexys) begin
    if (reset_total) begin
      state_q     <= ESPERA;
      idx_q       <= '0;
      frame_q     <= '0;
      datos_q     <= '0;
      en_vblank_q <= 1'b0;
      en_prev_q   <= 1'b0;
      parpadeo_q  <= 1'b0;
      ack_q       <= 1'b0;
      act_q       <= 1'b0;
    end else begin
      if (pixel_rate) en_vblank_q <= vis_blank;
      en_prev_q <= en_vblank_q;

      if (vblank_start) begin
        if (frame_q == FRAME_W'(PARPADEO_FRAMES-1)) begin
          frame_q    <= '0;
          parpadeo_q <= ~parpadeo_q;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end

      state_q <= state_d;
      idx_q   <= idx_d;
      // ack drops on the same edge that leaves ACK, so it is low in the
      // cycle right after req is seen low.
      ack_q   <= (state_q == ACK) && (state_d == ACK);
      act_q   <= (state_q == COPIA);

      for (int b = 0; b < NUM_BYTES; b++)
        if (state_q == COPIA && idx_q == IDX_W'(b))
          datos_q[8*b +: 8] <= hs.datos_in[8*b +: 8];
    end
  end

  assign hs.dato_ack   = ack_q;
  assign datos_vga     = datos_q;
  assign actualizando  = act_q;
  assign parpadeo      = parpadeo_q;
  assign en_vblank     = en_vblank_q;
endmodule

// File: tb/tb_control_actualizacion_vga.sv
module tb_control_actualizacion_vga;
  localparam int NB = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          prate = 1'b1;
  logic [9:0]    py = '0;
  logic [8*NB-1:0] dvga;
  logic          act, parp, evb;

  control_actualizacion_vga_if #(.NUM_BYTES(NB)) hs ();

  control_actualizacion_vga dut (
    .reloj_nexys (clk),
    .reset_total (rst),
    .pixel_rate  (prate),
    .pixel_y     (py),
    .hs          (hs),
    .datos_vga   (dvga),
    .actualizando(act),
    .parpadeo    (parp),
    .en_vblank   (evb)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  logic [8*NB-1:0] sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8*NB-1:0] obs, input logic [8*NB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for dato_ack; counts edges and cycles with actualizando high.
  task automatic wait_ack(input int lim, output int n, output int nact);
    n = 0;
    nact = 0;
    while (!hs.dato_ack && n < lim) begin
      tick();
      n++;
      if (act) nact++;
    end
  endtask

  task automatic sb_check(input string tag);
    logic [8*NB-1:0] exp;
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    chk(tag, dvga, exp);
  endtask

  initial begin
    int n, nact, hold, actc;
    logic [8*NB-1:0] d_a, d_b, d_seq, d_c, d_d;
    d_a   = 96'hDEADBEEF_CAFEF00D_12345678;
    d_b   = 96'hA1B2C3D4_E5F60718_293A4B5C;
    d_seq = 96'h0C0B0A09_08070605_04030201;
    d_c   = 96'h55AA55AA_0F0F0F0F_F0E1D2C3;
    d_d   = 96'h13579BDF_2468ACE0_77665544;

    hs.dato_req = 1'b0;
    hs.datos_in = '0;

    // Initial reset
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst_datos", dvga, '0);
    chk("rst_ack", 96'(hs.dato_ack), 96'd0);

    // Test 1: reset mid-copy (idx=5), then a clean transfer
    py = 10'd480; tick(); tick();
    chk("t1_vblank", 96'(evb), 96'd1);
    hs.datos_in = d_a; hs.dato_req = 1'b1;
    repeat (6) tick();            // ESPERA->COPIA, then bytes 0..4 copied
    chk("t1_mid_act", 96'(act), 96'd1);
    rst = 1'b1; hs.dato_req = 1'b0;
    tick();
    chk("t1_rst_datos", dvga, '0);
    chk("t1_rst_outs", 96'({hs.dato_ack, act, parp, evb}), 96'd0);
    tick(); tick(); rst = 1'b0;
    tick();                        // en_vblank back up (pixel_y still 480)
    sb.push_back(d_b);
    hs.datos_in = d_b; hs.dato_req = 1'b1;
    wait_ack(40, n, nact);
    chk("t1_ack_lat", 96'(n), 96'd14);
    sb_check("t1_data");
    hs.dato_req = 1'b0; tick();
    chk("t1_ack_drop", 96'(hs.dato_ack), 96'd0);

    // Test 2: request outside vblank waits in PENDIENTE
    py = 10'd100; tick(); tick();
    chk("t2_novblank", 96'(evb), 96'd0);
    sb.push_back(d_seq);
    hs.datos_in = d_seq; hs.dato_req = 1'b1;
    repeat (20) tick();
    chk("t2_pend_outs", 96'({hs.dato_ack, act}), 96'd0);
    chk("t2_pend_datos", dvga, d_b);
    py = 10'd480;
    wait_ack(40, n, nact);
    chk("t2_act_cycles", 96'(nact), 96'd12);
    chk("t2_ack", 96'(hs.dato_ack), 96'd1);
    chk("t2_byte0", 96'(dvga[7:0]), 96'h01);
    chk("t2_byte11", 96'(dvga[95:88]), 96'h0C);
    sb_check("t2_data");

    // Test 3: req held after ack -> no second copy; drop, then re-request
    hold = 0; actc = 0;
    repeat (50) begin
      tick();
      if (hs.dato_ack) hold++;
      if (act) actc++;
    end
    chk("t3_ack_hold", 96'(hold), 96'd50);
    chk("t3_no_copy", 96'(actc), 96'd0);
    chk("t3_datos_kept", dvga, d_seq);
    hs.dato_req = 1'b0; tick();
    chk("t3_ack_drop", 96'(hs.dato_ack), 96'd0);
    tick();
    sb.push_back(d_c);
    hs.datos_in = d_c; hs.dato_req = 1'b1;
    wait_ack(40, n, nact);
    chk("t3_ack_lat", 96'(n), 96'd14);
    sb_check("t3_data");
    hs.dato_req = 1'b0; tick(); tick();

    // Test 4: accepted at line 524, pixel_y wraps to 0 mid-copy
    py = 10'd524; tick();
    sb.push_back(d_d);
    hs.datos_in = d_d; hs.dato_req = 1'b1;
    repeat (4) tick();
    py = 10'd0; tick();
    chk("t4_vblank_fell", 96'(evb), 96'd0);
    wait_ack(40, n, nact);
    chk("t4_ack", 96'(hs.dato_ack), 96'd1);
    sb_check("t4_data");
    hs.dato_req = 1'b0; tick(); tick();

    // Test 5: 60 frames, pixel_rate every 4th cycle, coarse line sweep
    py = 10'd0; rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_parp_rst", 96'(parp), 96'd0);
    for (int f = 1; f <= 60; f++) begin
      for (int v = 0; v < 525; v += 15) begin
        py = 10'(v);
        for (int c = 0; c < 4; c++) begin
          prate = (c == 0);
          tick();
        end
      end
      chk($sformatf("t5_parp_f%0d", f), 96'(parp), 96'((f / 30) % 2));
    end
    prate = 1'b1;

    chk("sb_empty", 96'(sb.size()), 96'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
